// File: rtl/idct_precision_sched_if.sv
// Block-admission / precision-select bundle between DCT done and IDCT start.
// Carries scheduling controls in and block statistics back out.
interface idct_precision_sched_if #(
  parameter int CW  = 32,
  parameter int BCW = 16
);
  logic [1:0]     mode;
  logic [CW-1:0]  win_lo;
  logic [CW-1:0]  win_hi;
  logic [BCW-1:0] toggle_n;
  logic           start_in;
  logic           start_out;
  logic           rapx;
  logic [CW-1:0]  cyc_cnt;
  logic [BCW-1:0] acc_blks;
  logic [BCW-1:0] apx_blks;

  modport master (
    output mode, win_lo, win_hi, toggle_n, start_in,
    input  start_out, rapx, cyc_cnt, acc_blks, apx_blks
  );

  modport slave (
    input  mode, win_lo, win_hi, toggle_n, start_in,
    output start_out, rapx, cyc_cnt, acc_blks, apx_blks
  );
endinterface

// File: rtl/idct_precision_sched.sv
// Admits 64-sample blocks into the approximate IDCT, forwards start one
// cycle late and latches the per-block precision select.
module idct_precision_sched #(
  parameter int CW  = 32,
  parameter int BCW = 16
) (
  input logic                  clk,
  input logic                  reset,
  idct_precision_sched_if.slave bus
);

  logic           start_d;
  logic           rapx_q;
  logic           phase;
  logic [CW-1:0]  cyc;
  logic [BCW-1:0] acc;
  logic [BCW-1:0] apx;
  logic [BCW-1:0] grp;

  logic           admit;
  logic           apx_req;
  logic           win_hit;
  logic           grp_last;
  logic [BCW-1:0] grp_max;

  assign admit    = bus.start_in & ~start_d;
  assign win_hit  = (cyc > bus.win_lo) && (cyc < bus.win_hi);
  assign grp_max  = (bus.toggle_n == '0) ? BCW'(1) : bus.toggle_n;
  // >= keeps the group bounded if toggle_n shrinks mid-phase
  assign grp_last = grp >= (grp_max - BCW'(1));

  always_comb begin
    apx_req = 1'b0;
    unique case (1'b1)
      bus.mode == 2'd0: apx_req = 1'b0;
      bus.mode == 2'd1: apx_req = 1'b1;
      bus.mode == 2'd2: apx_req = win_hit;
      bus.mode == 2'd3: apx_req = phase;
      default:          apx_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_d <= 1'b0;
      rapx_q  <= 1'b0;
      phase   <= 1'b0;
      cyc     <= '0;
      acc     <= '0;
      apx     <= '0;
      grp     <= '0;
    end else begin
      start_d <= bus.start_in;
      if (cyc != '1)
        cyc <= cyc + CW'(1);
      if (admit) begin
        rapx_q <= apx_req;
        if (apx_req) begin
          if (apx != '1)
            apx <= apx + BCW'(1);
        end else begin
          if (acc != '1)
            acc <= acc + BCW'(1);
        end
        if (bus.mode == 2'd3) begin
          if (grp_last) begin
            grp   <= '0;
            phase <= ~phase;
          end else begin
            grp <= grp + BCW'(1);
          end
        end
      end
    end
  end

  assign bus.start_out = start_d;
  assign bus.rapx      = rapx_q;
  assign bus.cyc_cnt   = cyc;
  assign bus.acc_blks  = acc;
  assign bus.apx_blks  = apx;

endmodule

// File: tb/tb_idct_precision_sched.sv
// Directed bench for idct_precision_sched: full-width instance plus a
// CW=8/BCW=4 instance for counter saturation.
module tb_idct_precision_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  idct_precision_sched_if #(.CW(32), .BCW(16)) b1 ();
  idct_precision_sched_if #(.CW(8),  .BCW(4))  b2 ();

  idct_precision_sched #(.CW(32), .BCW(16)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );
  idct_precision_sched #(.CW(8), .BCW(4)) dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; bench-side model of the saturating cycle counter.
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    if (r) exp_cyc = 0;
    else if (exp_cyc != 32'hffff_ffff) exp_cyc = exp_cyc + 1;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_to(input logic [31:0] c);
    while (exp_cyc < c) tick();
  endtask

  task automatic pulse1(input int hi, input int lo, output logic r);
    b1.start_in = 1'b1;
    tick();
    r = b1.rapx;
    repeat (hi - 1) tick();
    b1.start_in = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    logic r;
    logic prev;
    logic [5:0] got;
    b1.mode = 2'd1; b1.win_lo = 0; b1.win_hi = 0;
    b1.toggle_n = 0; b1.start_in = 1'b1;
    b2.mode = 2'd0; b2.win_lo = 0; b2.win_hi = 0;
    b2.toggle_n = 0; b2.start_in = 1'b0;

    // Reset held 3 cycles with start_in high
    repeat (3) tick();
    chk("rst_start_out", 32'(b1.start_out), 0);
    chk("rst_rapx", 32'(b1.rapx), 0);
    chk("rst_cyc", b1.cyc_cnt, 0);
    chk("rst_acc", 32'(b1.acc_blks), 0);
    chk("rst_apx", 32'(b1.apx_blks), 0);
    reset = 1'b0;
    tick();
    chk("readmit_start_out", 32'(b1.start_out), 1);
    chk("readmit_rapx", 32'(b1.rapx), 1);
    chk("readmit_apx", 32'(b1.apx_blks), 1);
    chk("readmit_cyc", b1.cyc_cnt, 1);

    // Reset mid-block
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midrst_start_out", 32'(b1.start_out), 0);
    chk("midrst_rapx", 32'(b1.rapx), 0);
    chk("midrst_apx", 32'(b1.apx_blks), 0);
    reset = 1'b0;
    b1.start_in = 1'b0;
    tick();

    // Mode 0: three 64-cycle pulses, start_out tracks start_in by 1
    do_reset();
    b1.mode = 2'd0;
    prev = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 68; c++) begin
        b1.start_in = (c < 64);
        prev = b1.start_in;
        tick();
        chk("m0_start_out", 32'(b1.start_out), 32'(prev));
        chk("m0_rapx", 32'(b1.rapx), 0);
      end
    end
    chk("m0_acc", 32'(b1.acc_blks), 3);
    chk("m0_apx", 32'(b1.apx_blks), 0);

    // Mode 2: window (10,200), admissions at cycles 5, 100, 300
    do_reset();
    b1.mode = 2'd2; b1.win_lo = 10; b1.win_hi = 200;
    run_to(5);
    pulse1(8, 2, r);
    chk("m2_blk1", 32'(r), 0);
    run_to(100);
    b1.start_in = 1'b1;
    tick();
    chk("m2_blk2", 32'(b1.rapx), 1);
    run_to(250);
    chk("m2_blk2_hold", 32'(b1.rapx), 1);
    b1.start_in = 1'b0;
    run_to(300);
    pulse1(4, 2, r);
    chk("m2_blk3", 32'(r), 0);
    chk("m2_apx", 32'(b1.apx_blks), 1);
    chk("m2_acc", 32'(b1.acc_blks), 2);

    // Mode 2 with empty window
    b1.win_lo = 200; b1.win_hi = 100;
    pulse1(2, 1, r);
    chk("m2_empty", 32'(r), 0);

    // Mode 3, toggle_n=2
    do_reset();
    b1.mode = 2'd3; b1.toggle_n = 2;
    for (int i = 0; i < 6; i++) begin
      pulse1(2, 1, r);
      got[i] = r;
    end
    chk("m3_tn2_seq", 32'(got), 32'b001100);
    chk("m3_tn2_acc", 32'(b1.acc_blks), 4);
    chk("m3_tn2_apx", 32'(b1.apx_blks), 2);

    // Mode 3, toggle_n=0 behaves as 1
    do_reset();
    b1.toggle_n = 0;
    for (int i = 0; i < 6; i++) begin
      pulse1(2, 1, r);
      got[i] = r;
    end
    chk("m3_tn0_seq", 32'(got), 32'b101010);

    // Leaving mode 3 preserves phase
    do_reset();
    b1.toggle_n = 1;
    pulse1(2, 1, r);
    chk("m3_keep_a", 32'(r), 0);
    b1.mode = 2'd0;
    pulse1(2, 1, r);
    chk("m3_keep_b", 32'(r), 0);
    b1.mode = 2'd3;
    pulse1(2, 1, r);
    chk("m3_keep_c", 32'(r), 1);

    // Mode changed 30 cycles into a block
    do_reset();
    b1.mode = 2'd0;
    b1.start_in = 1'b1;
    repeat (30) tick();
    b1.mode = 2'd1;
    repeat (34) tick();
    chk("mid_mode_hold", 32'(b1.rapx), 0);
    b1.start_in = 1'b0;
    tick();
    chk("mid_mode_end", 32'(b1.rapx), 0);
    pulse1(2, 1, r);
    chk("mid_mode_next", 32'(r), 1);

    // Reduced-width instance: saturation
    do_reset();
    b2.mode = 2'd2; b2.win_lo = 250; b2.win_hi = 255;
    run_to(252);
    b2.start_in = 1'b1;
    tick();
    chk("sat_win_in", 32'(b2.rapx), 1);
    b2.start_in = 1'b0;
    run_to(300);
    chk("sat_cyc", 32'(b2.cyc_cnt), 255);
    b2.start_in = 1'b1;
    tick();
    chk("sat_win_edge", 32'(b2.rapx), 0);
    chk("sat_cyc_hold", 32'(b2.cyc_cnt), 255);
    b2.start_in = 1'b0;
    tick();
    b2.mode = 2'd1;
    for (int i = 0; i < 20; i++) begin
      b2.start_in = 1'b1;
      tick();
      b2.start_in = 1'b0;
      tick();
    end
    chk("sat_apx", 32'(b2.apx_blks), 15);
    chk("sat_acc", 32'(b2.acc_blks), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
